// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-port memory between fetch and load/store ports.
// Latency: strobes for MEM_LATENCY cycles after the grant edge, ready pulse the cycle after; MEM_LATENCY+2 per access.
// Backpressure: a waiting requester holds req until its ready; no preemption. Stats counters: `define MEM_ARB_STATS_EN.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_re,
    output logic              m_we,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              busy
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_ifetch,
    output logic [15:0]       stat_dacc,
    output logic [15:0]       stat_conflict
`endif
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : gLatencyCheck
        $error("mem_port_arbiter: MEM_LATENCY must be within 1..15");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {INSTR, DATA} port_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

    state_t     state;
    port_t      lastGrant;
    logic [3:0] cnt;
    logic       weLat;
    logic       anyReq;
    logic       bothReq;
    logic       grantData;

    assign anyReq  = i_req | d_req;
    assign bothReq = i_req & d_req;
    // On a tie the port that did not win last time goes; lastGrant resets to INSTR so data wins the first tie.
    assign grantData = bothReq ? (lastGrant == INSTR) : d_req;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            lastGrant <= INSTR;
            cnt       <= '0;
            weLat     <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_re      <= 1'b0;
            m_we      <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        lastGrant <= grantData ? DATA : INSTR;
                        m_addr    <= grantData ? d_addr : i_addr;
                        if (grantData) begin
                            m_wdata <= d_wdata;
                        end
                        weLat     <= grantData & d_we;
                        m_re      <= ~(grantData & d_we);
                        m_we      <= grantData & d_we;
                        cnt       <= CNT_INIT;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        // Memory data is only valid in this last strobe cycle.
                        if (!weLat) begin
                            if (lastGrant == DATA) begin
                                d_rdata <= m_rdata;
                            end else begin
                                i_rdata <= m_rdata;
                            end
                        end
                        m_re    <= 1'b0;
                        m_we    <= 1'b0;
                        i_ready <= (lastGrant == INSTR);
                        d_ready <= (lastGrant == DATA);
                        state   <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    i_ready <= 1'b0;
                    d_ready <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_ifetch   <= '0;
            stat_dacc     <= '0;
            stat_conflict <= '0;
        end else if (state == IDLE && anyReq) begin
            if (grantData) begin
                stat_dacc <= stat_dacc + 16'd1;
            end else begin
                stat_ifetch <= stat_ifetch + 16'd1;
            end
            if (bothReq) begin
                stat_conflict <= stat_conflict + 16'd1;
            end
        end
    end
`endif

endmodule
